// File: rtl/v_query_scan.sv
// Scans one product's level list in v by issuing level queries and re-emitting the responses as an ordered entry stream.
// Latency: first query the cycle after request accept; each entry appears one cycle after its response.
// Backpressure: request accepted only when idle and v not busy; issue stalls on i_busy or a full window; entries have no backpressure.
package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [7:0]  level_t;
    typedef logic [31:0] key_t;
    typedef logic [15:0] size_t;
    typedef logic [7:0]  listsize_t;
endpackage

module v_query_scan #(
    parameter int LEVELS_N        = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_busy,
    input  logic               i_req_vld,
    input  v_pkg::id_t         i_req_prod_id,
    output logic               o_req_rdy,
    output logic               o_lut_vld,
    output v_pkg::id_t         o_lut_prod_id,
    output v_pkg::level_t      o_lut_level,
    input  logic               i_lut_vld_r,
    input  v_pkg::key_t        i_lut_key,
    input  v_pkg::size_t       i_lut_size,
    input  logic               i_lut_error,
    input  v_pkg::listsize_t   i_lut_listsize,
    output logic               o_ent_vld_r,
    output v_pkg::level_t      o_ent_level_r,
    output v_pkg::key_t        o_ent_key_r,
    output v_pkg::size_t       o_ent_size_r,
    output logic               o_ent_error_r,
    output logic               o_ent_last_r,
    output logic               o_scan_busy_r
);
    // Counter must hold MAX_OUTSTANDING itself; target holds up to LEVELS_N.
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TW = $bits(v_pkg::level_t) + 1;

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_WAIT0, S_ISSUE, S_DRAIN} state_t;

    state_t          state;
    v_pkg::id_t      prod_id;
    logic [CW-1:0]   cnt;
    v_pkg::level_t   issue_lvl;
    v_pkg::level_t   rsp_lvl;
    logic [TW-1:0]   target;

    logic            req_acc;
    logic            rsp_acc;
    logic            issue;
    logic            rsp_last;
    logic [TW-1:0]   t_new;

    assign o_req_rdy = (state == S_IDLE) & ~i_busy;

    // Handshakes, issue gating and last-entry decision for the current cycle.
    always_comb begin
        req_acc = i_req_vld & o_req_rdy;
        // Responses with nothing in flight (idle, or stale after reset) are dropped.
        rsp_acc = i_lut_vld_r & (cnt != '0);
        issue   = 1'b0;
        if (!i_busy) begin
            if (state == S_HEAD)
                issue = 1'b1;
            else if (state == S_ISSUE)
                issue = (cnt < CW'(MAX_OUTSTANDING)) & ({1'b0, issue_lvl} < target);
        end
        // Scan length is fixed from the level-0 response and never re-evaluated.
        if (32'(i_lut_listsize) < 32'(LEVELS_N))
            t_new = TW'(i_lut_listsize);
        else
            t_new = TW'(LEVELS_N);
        if (state == S_WAIT0)
            rsp_last = i_lut_error | (t_new <= TW'(1));
        else
            rsp_last = ({1'b0, rsp_lvl} == target - TW'(1));
        o_lut_vld     = issue;
        o_lut_prod_id = issue ? prod_id : '0;
        o_lut_level   = issue ? issue_lvl : '0;
    end

    // Scan FSM with in-flight counter, level counters and registered entry output.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state         <= S_IDLE;
            prod_id       <= '0;
            cnt           <= '0;
            issue_lvl     <= '0;
            rsp_lvl       <= '0;
            target        <= '0;
            o_ent_vld_r   <= 1'b0;
            o_ent_level_r <= '0;
            o_ent_key_r   <= '0;
            o_ent_size_r  <= '0;
            o_ent_error_r <= 1'b0;
            o_ent_last_r  <= 1'b0;
            o_scan_busy_r <= 1'b0;
        end else begin
            cnt         <= cnt + CW'(issue) - CW'(rsp_acc);
            o_ent_vld_r <= rsp_acc;
            if (rsp_acc) begin
                o_ent_level_r <= rsp_lvl;
                o_ent_key_r   <= i_lut_key;
                o_ent_size_r  <= i_lut_size;
                o_ent_error_r <= i_lut_error;
                o_ent_last_r  <= rsp_last;
                rsp_lvl       <= rsp_lvl + 1'b1;
            end
            if (issue)
                issue_lvl <= issue_lvl + 1'b1;
            case (state)
                S_IDLE: begin
                    // Busy stays up while the last entry is visible, drops the cycle after.
                    o_scan_busy_r <= req_acc;
                    if (req_acc) begin
                        prod_id   <= i_req_prod_id;
                        issue_lvl <= '0;
                        rsp_lvl   <= '0;
                        state     <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (issue)
                        state <= S_WAIT0;
                end
                S_WAIT0: begin
                    if (rsp_acc) begin
                        target <= t_new;
                        state  <= rsp_last ? S_IDLE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue && ({1'b0, issue_lvl} == target - TW'(1)))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rsp_acc && rsp_last)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_query_scan.sv
// Directed bench for v_query_scan with a behavioural list-engine responder and expected-entry scoreboard.
// Responses return after a programmable fixed latency in issue order.
// Entries are checked every cycle against the scoreboard; the DUT has no output backpressure.
module tb_v_query_scan;
    localparam int LEVELS_N = 16;
    localparam int MAXO     = 4;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               i_busy = 1'b0;
    logic               i_req_vld = 1'b0;
    v_pkg::id_t         i_req_prod_id = '0;
    logic               o_req_rdy;
    logic               o_lut_vld;
    v_pkg::id_t         o_lut_prod_id;
    v_pkg::level_t      o_lut_level;
    logic               i_lut_vld_r = 1'b0;
    v_pkg::key_t        i_lut_key = '0;
    v_pkg::size_t       i_lut_size = '0;
    logic               i_lut_error = 1'b0;
    v_pkg::listsize_t   i_lut_listsize = '0;
    logic               o_ent_vld_r;
    v_pkg::level_t      o_ent_level_r;
    v_pkg::key_t        o_ent_key_r;
    v_pkg::size_t       o_ent_size_r;
    logic               o_ent_error_r;
    logic               o_ent_last_r;
    logic               o_scan_busy_r;

    v_query_scan #(.LEVELS_N(LEVELS_N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .arst_n(arst_n), .i_busy(i_busy),
        .i_req_vld(i_req_vld), .i_req_prod_id(i_req_prod_id), .o_req_rdy(o_req_rdy),
        .o_lut_vld(o_lut_vld), .o_lut_prod_id(o_lut_prod_id), .o_lut_level(o_lut_level),
        .i_lut_vld_r(i_lut_vld_r), .i_lut_key(i_lut_key), .i_lut_size(i_lut_size),
        .i_lut_error(i_lut_error), .i_lut_listsize(i_lut_listsize),
        .o_ent_vld_r(o_ent_vld_r), .o_ent_level_r(o_ent_level_r), .o_ent_key_r(o_ent_key_r),
        .o_ent_size_r(o_ent_size_r), .o_ent_error_r(o_ent_error_r), .o_ent_last_r(o_ent_last_r),
        .o_scan_busy_r(o_scan_busy_r)
    );

    always #5 clk = ~clk;

    typedef struct { int lvl; int due; int gen; int prod; } pend_t;
    typedef struct { int lvl; logic [31:0] key; logic [15:0] size; bit err; bit last; } ent_t;

    pend_t pend[$];
    ent_t  exp_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, gen = 0, out_cnt = 0;
    int cur_prod = 0, cur_ls = 0, cur_lat = 1;
    logic [63:0] cur_mask = '0;
    int exp_issue_lvl = 0, q_count = 0, ent_count = 0;
    logic [31:0] first_key = '0;
    logic [15:0] err_vec = '0;
    bit scan_done = 0, busy_chk = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] kf(input int prod, input int lvl);
        return 32'h1000_0000 | (32'(prod) << 8) | 32'(lvl);
    endfunction
    function automatic logic [15:0] sf(input int lvl);
        return 16'(100 + lvl);
    endfunction
    function automatic bit ef(input int lvl);
        return (lvl >= cur_ls) || cur_mask[lvl];
    endfunction

    // Expected entries straight from the scan rules: T=min(listsize,LEVELS_N), early stop on level-0 error or T<=1.
    task automatic build_expected(output int nq);
        int t;
        t = (cur_ls < LEVELS_N) ? cur_ls : LEVELS_N;
        exp_q.delete();
        if (ef(0) || t <= 1) begin
            exp_q.push_back('{0, kf(cur_prod, 0), sf(0), ef(0), 1'b1});
            nq = 1;
        end else begin
            for (int l = 0; l < t; l++)
                exp_q.push_back('{l, kf(cur_prod, l), sf(l), ef(l), (l == t - 1)});
            nq = t;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Checker plus list-engine responder, both evaluated mid-cycle.
    always @(negedge clk) begin
        ent_t e;
        if (arst_n) begin
            if (busy_chk) begin
                chk("scan_busy_drop", o_scan_busy_r, 0);
                busy_chk = 0;
            end
            if (o_lut_vld) begin
                chk("lut_while_busy", i_busy, 0);
                chk("outstanding_limit", out_cnt < MAXO, 1);
                chk("lut_level_order", o_lut_level, exp_issue_lvl);
                chk("lut_prod", o_lut_prod_id, cur_prod);
                exp_issue_lvl++;
                q_count++;
            end else begin
                chk("lut_idle_zero", {o_lut_prod_id, o_lut_level}, 0);
            end
            if (o_ent_vld_r) begin
                ent_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", o_ent_level_r, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("ent_level", o_ent_level_r, e.lvl);
                    chk("ent_key", o_ent_key_r, e.key);
                    chk("ent_size", o_ent_size_r, e.size);
                    chk("ent_error", o_ent_error_r, e.err);
                    chk("ent_last", o_ent_last_r, e.last);
                    chk("scan_busy_during", o_scan_busy_r, 1);
                    if (ent_count == 1) first_key = o_ent_key_r;
                    if (e.lvl < 16) err_vec[e.lvl] = o_ent_error_r;
                    if (e.last) begin
                        scan_done = 1;
                        busy_chk = 1;
                    end
                end
            end
            if (o_lut_vld) begin
                pend.push_back('{int'(o_lut_level), cyc + cur_lat, gen, int'(o_lut_prod_id)});
                out_cnt++;
            end
        end
        i_lut_vld_r = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            i_lut_vld_r    = 1'b1;
            i_lut_key      = kf(pend[0].prod, pend[0].lvl);
            i_lut_size     = sf(pend[0].lvl);
            i_lut_error    = ef(pend[0].lvl);
            i_lut_listsize = 8'(cur_ls);
            if (pend[0].gen == gen) out_cnt--;
            void'(pend.pop_front());
        end
    end

    task automatic start_scan(input int prod, input int ls, input int lat, input logic [63:0] mask, output int nq);
        int k;
        cur_prod = prod; cur_ls = ls; cur_lat = lat; cur_mask = mask;
        exp_issue_lvl = 0; q_count = 0; ent_count = 0; err_vec = '0;
        scan_done = 0;
        build_expected(nq);
        @(posedge clk); #1;
        i_req_vld = 1'b1;
        i_req_prod_id = 8'(prod);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_req_rdy && k < 20);
        if (!o_req_rdy) chk("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        i_req_vld = 1'b0;
    endtask

    task automatic run_scan(input int prod, input int ls, input int lat, input logic [63:0] mask, input int busy_at);
        int nq, k;
        start_scan(prod, ls, lat, mask, nq);
        k = 0;
        while (!scan_done && k < 400) begin
            if (k == busy_at) i_busy = 1'b1;
            if (k == busy_at + 5) i_busy = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        i_busy = 1'b0;
        if (!scan_done) chk("scan_timeout", 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("query_count", q_count, nq);
    endtask

    initial begin
        int nq, k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ent_vld", o_ent_vld_r, 0);
        chk("rst_scan_busy", o_scan_busy_r, 0);
        chk("rst_lut_vld", o_lut_vld, 0);
        chk("rst_ent_data", {o_ent_level_r, o_ent_key_r, o_ent_size_r, o_ent_error_r, o_ent_last_r}, 0);
        #1 arst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_rdy", o_req_rdy, 1);

        // Basic scan: 5 levels, latency 3.
        run_scan(3, 5, 3, '0, -1);
        chk("t1_entries", ent_count, 5);
        chk("t1_key0", first_key, 32'h1000_0300);

        // Level-0 error with empty list.
        run_scan(4, 0, 2, '0, -1);
        chk("t2_entries", ent_count, 1);
        chk("t2_queries", q_count, 1);
        chk("t2_err_bits", err_vec, 16'h0001);
        chk("t2_rdy_after", o_req_rdy, 1);

        // Single-level list: one entry, no error.
        run_scan(5, 1, 1, '0, -1);
        chk("t_single_entries", ent_count, 1);

        // Long list clipped to LEVELS_N, window-limited.
        run_scan(6, 40, 8, '0, -1);
        chk("t3_entries", ent_count, 16);
        chk("t3_queries", q_count, 16);

        // Busy at request, then busy mid-issue.
        @(posedge clk); #1;
        i_busy = 1'b1;
        i_req_vld = 1'b1;
        i_req_prod_id = 8'd7;
        repeat (3) begin
            @(negedge clk);
            chk("busy_req_rdy", o_req_rdy, 0);
            @(posedge clk); #1;
        end
        i_req_vld = 1'b0;
        i_busy = 1'b0;
        @(negedge clk);
        chk("busy_no_scan", o_scan_busy_r, 0);
        run_scan(7, 12, 3, '0, 6);
        chk("t4_entries", ent_count, 12);

        // List shrank: level-2 error, T=4.
        run_scan(8, 4, 2, 64'h4, -1);
        chk("t5_entries", ent_count, 4);
        chk("t5_err_bits", err_vec, 16'h0004);

        // Reset mid-scan with queries outstanding.
        start_scan(9, 10, 6, '0, nq);
        k = 0;
        while (out_cnt < 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_outstanding", out_cnt >= 2, 1);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ent_vld", o_ent_vld_r, 0);
        chk("midrst_scan_busy", o_scan_busy_r, 0);
        chk("midrst_lut_vld", o_lut_vld, 0);
        exp_q.delete();
        gen++;
        out_cnt = 0;
        busy_chk = 0;
        ent_count = 0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        k = 0;
        while (pend.size() > 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("late_rsp_drained", pend.size(), 0);
        @(negedge clk);
        chk("rst_no_late_entries", ent_count, 0);
        chk("rst_state_idle", o_scan_busy_r, 0);
        run_scan(10, 6, 2, '0, -1);
        chk("t6_entries", ent_count, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
